// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style main control FSM.
// Moore outputs per state; PCEn folds in the branch/Zero decision.
module multicycle_control_unit #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic                   Zero,
  output logic                   PCEn,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   IorD,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSrc,
  output logic [STATE_WIDTH-1:0] State
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH   = 'd0,
    DECODE  = 'd1,
    MEMADR  = 'd2,
    MEMRD   = 'd3,
    MEMWB   = 'd4,
    MEMWR   = 'd5,
    EXECUTE = 'd6,
    ALUWB   = 'd7,
    BEQ     = 'd8,
    ADDIEX  = 'd9,
    ADDIWB  = 'd10,
    JUMP    = 'd11,
    BNE     = 'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state;
  state_t state_nxt;
  logic   pc_write;
  logic   branch;
  logic   branch_ne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = FETCH;
    unique case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW:   state_nxt = MEMADR;
          OP_SW:   state_nxt = MEMADR;
          OP_R:    state_nxt = EXECUTE;
          OP_BEQ:  state_nxt = BEQ;
          OP_BNE:  state_nxt = BNE;
          OP_ADDI: state_nxt = ADDIEX;
          OP_J:    state_nxt = JUMP;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        if (Opcode == OP_SW) begin
          state_nxt = MEMWR;
        end else begin
          state_nxt = MEMRD;
        end
      end
      MEMRD:   state_nxt = MEMWB;
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = 1'b1;
        pc_write = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      BNE: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 2'b01;
        branch_ne = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PCEn  = pc_write
               | (branch & Zero)
               | (branch_ne & ~Zero);
  assign State = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Vector table of per-edge expectations plus reset corner cases.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       PCEn;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic [3:0] State;

  multicycle_control_unit #(.STATE_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .Zero     (Zero),
    .PCEn     (PCEn),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSrc    (PCSrc),
    .State    (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCEn,IRWrite,RegWrite,MemWrite,IorD,RegDst,MemtoReg,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSrc}
  localparam logic [13:0] C_FETCH = 14'b1_1_0_0_0_0_0_0_01_00_00;
  localparam logic [13:0] C_DEC   = 14'b0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [13:0] C_MADR  = 14'b0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [13:0] C_MRD   = 14'b0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [13:0] C_MWR   = 14'b0_0_0_1_1_0_0_0_00_00_00;
  localparam logic [13:0] C_MWB   = 14'b0_0_1_0_0_0_1_0_00_00_00;
  localparam logic [13:0] C_EXE   = 14'b0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [13:0] C_AWB   = 14'b0_0_1_0_0_1_0_0_00_00_00;
  localparam logic [13:0] C_IWB   = 14'b0_0_1_0_0_0_0_0_00_00_00;
  localparam logic [13:0] C_BR_T  = 14'b1_0_0_0_0_0_0_1_00_01_01;
  localparam logic [13:0] C_BR_N  = 14'b0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [13:0] C_JMP   = 14'b1_0_0_0_0_0_0_0_00_00_10;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BQ   = 6'b000100;
  localparam logic [5:0] BN   = 6'b000101;
  localparam logic [5:0] AI   = 6'b001000;
  localparam logic [5:0] JP   = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [5:0] BAD2 = 6'b000011;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [13:0] ctrl;
    string       name;
  } vec_t;

  vec_t tv[$];
  int   checks;
  int   errors;

  function automatic logic [13:0] ctrl_now();
    return {PCEn, IRWrite, RegWrite, MemWrite, IorD, RegDst,
            MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
  endfunction

  task automatic add(input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [13:0] c,
                     input string nm);
    vec_t v;
    v.op = op;
    v.zero = z;
    v.st = st;
    v.ctrl = c;
    v.name = nm;
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] st,
                       input logic [13:0] c);
    logic [13:0] got;
    got = ctrl_now();
    checks++;
    if (State !== st || got !== c) begin
      errors++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               nm, State, got, st, c);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Opcode = LW;
    Zero   = 1'b0;
    reset  = 1'b0;

    add(LW, 0, 1, C_DEC,  "lw_dec");
    add(LW, 0, 2, C_MADR, "lw_madr");
    add(LW, 1, 3, C_MRD,  "lw_mrd");
    add(LW, 0, 4, C_MWB,  "lw_mwb");
    add(LW, 0, 0, C_FETCH,"lw_done");
    add(SW, 0, 1, C_DEC,  "sw_dec");
    add(SW, 0, 2, C_MADR, "sw_madr");
    add(SW, 0, 5, C_MWR,  "sw_mwr");
    add(SW, 0, 0, C_FETCH,"sw_done");
    add(RT, 0, 1, C_DEC,  "r_dec");
    add(RT, 0, 6, C_EXE,  "r_exe");
    add(LW, 1, 7, C_AWB,  "r_awb_opchg");
    add(RT, 0, 0, C_FETCH,"r_done");
    add(JP, 0, 1, C_DEC,  "j_dec");
    add(JP, 0, 11, C_JMP, "j_jump");
    add(JP, 1, 0, C_FETCH,"j_done");
    add(BQ, 1, 1, C_DEC,  "beq1_dec");
    add(BQ, 1, 8, C_BR_T, "beq_z1");
    add(BQ, 1, 0, C_FETCH,"beq1_done");
    add(BQ, 0, 1, C_DEC,  "beq0_dec");
    add(BQ, 0, 8, C_BR_N, "beq_z0");
    add(BQ, 0, 0, C_FETCH,"beq0_done");
    add(BN, 1, 1, C_DEC,  "bne1_dec");
    add(BN, 1, 12, C_BR_N,"bne_z1");
    add(BN, 1, 0, C_FETCH,"bne1_done");
    add(BN, 0, 1, C_DEC,  "bne0_dec");
    add(BN, 0, 12, C_BR_T,"bne_z0");
    add(BN, 0, 0, C_FETCH,"bne0_done");
    add(AI, 0, 1, C_DEC,  "addi_dec");
    add(AI, 1, 9, C_MADR, "addi_ex");
    add(RT, 0, 10, C_IWB, "addi_wb_opchg");
    add(AI, 0, 0, C_FETCH,"addi_done");
    add(BAD, 0, 1, C_DEC, "bad_dec");
    add(BAD, 0, 0, C_FETCH,"bad_done");
    add(BAD2, 1, 1, C_DEC,"bad2_dec");
    add(BAD2, 1, 0, C_FETCH,"bad2_done");

    #2;
    check("reset_async", 4'd0, C_FETCH);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", 4'd0, C_FETCH);
    reset = 1'b1;

    foreach (tv[i]) begin
      Opcode = tv[i].op;
      Zero   = tv[i].zero;
      @(posedge clk);
      #1;
      check(tv[i].name, tv[i].st, tv[i].ctrl);
    end

    Opcode = LW;
    Zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_lw_mrd", 4'd3, C_MRD);
    #1;
    reset = 1'b0;
    #1;
    check("mid_reset_async", 4'd0, C_FETCH);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("resume_dec", 4'd1, C_DEC);
    Opcode = SW;
    @(posedge clk);
    #1;
    check("resume_madr", 4'd2, C_MADR);
    @(posedge clk);
    #1;
    check("resume_mwr", 4'd5, C_MWR);
    @(posedge clk);
    #1;
    check("resume_fetch", 4'd0, C_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
